// File: rtl/upa1_coef_update_pkg.sv
// Shared ADPCM constants for the adaptive predictor datapath.
// Holds the coefficient width, the UPA1 gain steps and the leak bias.
package upa1_coef_update_pkg;

  localparam int          COEF_WIDTH = 16;
  localparam logic [15:0] GAIN_POS   = 16'h00C0;
  localparam logic [15:0] GAIN_NEG   = 16'hFF40;
  localparam logic [15:0] LEAK_BIAS  = 16'hFF00;

  // Two's complement negate; the carry out of bit 15 is dropped.
  function automatic logic [15:0] neg16(input logic [15:0] value);
    neg16 = 16'h0000 - value;
  endfunction

endpackage

// File: rtl/upa1_coef_update.sv
// G.726 UPA1: updates the first-order pole coefficient a1 combinationally.
// Clock, reset and scan ports exist only so DFT treats every ADPCM block alike.
module upa1_coef_update
  import upa1_coef_update_pkg::*;
#(
  parameter int          WIDTH = COEF_WIDTH,
  parameter logic [15:0] GAIN  = GAIN_POS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  input  logic        scan_enable,
  input  logic        test_mode,
  input  logic        PK0,
  input  logic        PK1,
  input  logic [15:0] A1,
  input  logic        SIGPK,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4,
  output logic [15:0] A1T
);

  localparam logic [15:0] GAIN_N = 16'h0000 - GAIN;

  logic        pks;
  logic        a1s;
  logic [15:0] uga1;
  logic [15:0] a1_shr;
  logic [15:0] leak_arg;
  logic [15:0] ula1;
  logic [15:0] ua1h;
  logic        unused_dft;

  assign pks = PK0 ^ PK1;
  assign a1s = A1[15];

  // A zero partial signal carries no sign information, so the gain is skipped.
  assign uga1 = SIGPK ? 16'h0000 : (pks ? GAIN_N : GAIN);

  // Sign-extending the logical shift via the bias gives A1 >>> 8.
  assign a1_shr   = {8'h00, A1[15:8]};
  assign leak_arg = a1s ? (a1_shr + LEAK_BIAS) : a1_shr;
  assign ula1     = neg16(leak_arg);

  assign ua1h = uga1 + ula1;
  assign A1T  = A1 + ua1h;

  assign scan_out0 = scan_in0;
  assign scan_out1 = scan_in1;
  assign scan_out2 = scan_in2;
  assign scan_out3 = scan_in3;
  assign scan_out4 = scan_in4;

  assign unused_dft = ^{clk, reset, scan_enable, test_mode, (WIDTH == 16)};

endmodule

// File: tb/tb_upa1_coef_update.sv
// Directed-vector bench for upa1_coef_update with hand-computed A1T values.
// Inputs change after the rising edge; outputs are sampled on the falling edge.
module tb_upa1_coef_update;

  logic        clk;
  logic        reset;
  logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
  logic        scan_enable;
  logic        test_mode;
  logic        PK0, PK1, SIGPK;
  logic [15:0] A1;
  logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
  logic [15:0] A1T;

  int n_vec = 0;
  int n_err = 0;

  upa1_coef_update dut (
    .clk        (clk),
    .reset      (reset),
    .scan_in0   (scan_in0),
    .scan_in1   (scan_in1),
    .scan_in2   (scan_in2),
    .scan_in3   (scan_in3),
    .scan_in4   (scan_in4),
    .scan_enable(scan_enable),
    .test_mode  (test_mode),
    .PK0        (PK0),
    .PK1        (PK1),
    .A1         (A1),
    .SIGPK      (SIGPK),
    .scan_out0  (scan_out0),
    .scan_out1  (scan_out1),
    .scan_out2  (scan_out2),
    .scan_out3  (scan_out3),
    .scan_out4  (scan_out4),
    .A1T        (A1T)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: A1T=%h expected %h", tag, got, exp);
    end
    $display("vec %0d %s: A1=%h PK0=%b PK1=%b SIGPK=%b A1T=%h exp=%h",
             n_vec, tag, A1, PK0, PK1, SIGPK, got, exp);
  endtask

  task automatic apply(input string tag, input logic [15:0] a1, input logic pk0,
                       input logic pk1, input logic sigpk, input logic [15:0] exp);
    @(posedge clk);
    #1;
    A1 = a1; PK0 = pk0; PK1 = pk1; SIGPK = sigpk;
    @(negedge clk);
    check16(tag, A1T, exp);
  endtask

  task automatic check_scan(input string tag, input logic [4:0] pattern);
    logic [4:0] got;
    @(posedge clk);
    #1;
    {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0} = pattern;
    @(negedge clk);
    got = {scan_out4, scan_out3, scan_out2, scan_out1, scan_out0};
    n_vec++;
    assert (got === pattern)
    else begin
      n_err++;
      $error("FAIL %s: scan_out=%b expected %b", tag, got, pattern);
    end
    $display("vec %0d %s: scan_out=%b exp=%b", n_vec, tag, got, pattern);
  endtask

  initial begin
    reset = 1'b1; scan_enable = 1'b0; test_mode = 1'b0;
    {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0} = 5'b00000;
    A1 = 16'h0000; PK0 = 1'b0; PK1 = 1'b0; SIGPK = 1'b0;
    @(negedge clk);
    check16("in_reset_zero", A1T, 16'h00C0);
    @(posedge clk);
    #1 reset = 1'b0;

    apply("zero_gain_pos",   16'h0000, 1'b0, 1'b0, 1'b0, 16'h00C0);
    apply("zero_gain_neg",   16'h0000, 1'b1, 1'b0, 1'b0, 16'hFF40);
    apply("zero_pk11",       16'h0000, 1'b1, 1'b1, 1'b0, 16'h00C0);
    apply("zero_pk01",       16'h0000, 1'b0, 1'b1, 1'b0, 16'hFF40);
    apply("zero_sigpk",      16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000);
    apply("leak_only_1000",  16'h1000, 1'b1, 1'b1, 1'b1, 16'h0FF0);
    apply("neg_8000_leak",   16'h8000, 1'b0, 1'b0, 1'b1, 16'h8080);
    apply("neg_8000_sigpk",  16'h8000, 1'b1, 1'b0, 1'b1, 16'h8080);
    apply("neg_8000_gain",   16'h8000, 1'b0, 1'b0, 1'b0, 16'h8140);
    apply("ffff_wrap",       16'hFFFF, 1'b0, 1'b1, 1'b0, 16'hFF40);
    apply("pos_max_wrap",    16'h7FFF, 1'b0, 1'b0, 1'b0, 16'h8040);
    apply("mid_1234",        16'h1234, 1'b1, 1'b1, 1'b0, 16'h12E2);
    apply("neg_f000",        16'hF000, 1'b1, 1'b0, 1'b0, 16'hEF50);
    apply("shift_zero_00ff", 16'h00FF, 1'b0, 1'b0, 1'b1, 16'h00FF);
    apply("shift_one_0100",  16'h0100, 1'b0, 1'b0, 1'b1, 16'h00FF);
    apply("neg_ff00",        16'hFF00, 1'b1, 1'b1, 1'b1, 16'hFF01);

    // Reset pulse mid-sequence must leave the combinational result alone.
    apply("pre_reset_1234",  16'h1234, 1'b0, 1'b0, 1'b0, 16'h12E2);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check16("during_reset", A1T, 16'h12E2);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check16("after_reset", A1T, 16'h12E2);

    check_scan("scan_pat_a", 5'b10110);
    check_scan("scan_pat_b", 5'b01001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/upa1_coef_update.md
Name: upa1_coef_update

Overview:
- Combinational ITU-T G.726 ADPCM "UPA1" block: computes the updated first-order pole predictor coefficient A1T from the current coefficient A1.
- Update terms: a leak term (A1 scaled by 2^-8) and a gain term driven by the sign agreement of the last two partial reconstructed signals (PK0, PK1).
- Sits in the adaptive predictor datapath; A1T feeds the LIMD limiter.
- Clock, reset and scan ports exist for DFT uniformity with the other ADPCM sub-blocks.

Parameters:
- WIDTH, 16, coefficient word width (two's complement, G.726 fixed point). Only the value 16 is supported.
- GAIN, 16'h00C0, gain step magnitude (192). Its negative, 16'hFF40, is derived as (2^16 - GAIN).

Ports:
- clk  input  1  system clock; unused by the datapath.
- reset  input  1  asynchronous, active-high reset; no datapath state.
- scan_in0..scan_in4  input  1 each  scan chain inputs.
- scan_enable  input  1  scan shift enable.
- test_mode  input  1  DFT test mode.
- PK0  input  1  sign of current partial reconstructed signal p(k).
- PK1  input  1  sign of p(k-1).
- A1  input  16  current coefficient a1(k), two's complement.
- SIGPK  input  1  1 when p(k) = 0; suppresses the gain term.
- scan_out0..scan_out4  output  1 each  scan chain outputs.
- A1T  output  16  unlimited updated coefficient.

Behaviour:
- Purely combinational from PK0, PK1, A1 and SIGPK to A1T.
  - No registers; zero latency.
  - A1T must be valid within half a clock period of an input change.
  - clk and reset do not affect A1T, including during reset assertion.
- PKS = PK0 XOR PK1.
- UGA1 (16 bit):
  - SIGPK = 1: 0, regardless of PKS.
  - SIGPK = 0, PKS = 0: 16'h00C0.
  - SIGPK = 0, PKS = 1: 16'hFF40.
- A1S = A1[15].
- ULA1 (16 bit, mod 2^16):
  - A1S = 0: (2^16 - (A1 >> 8)) mod 2^16, logical shift.
  - A1S = 1: (2^16 - ((A1 >> 8) + 16'hFF00)) mod 2^16.
  - Equivalent: ULA1 = -(A1 >>> 8), arithmetic shift.
- UA1H = (UGA1 + ULA1) mod 2^16.
- A1T = (A1 + UA1H) mod 2^16.
  - All carries out of bit 15 are discarded.
  - No saturation; limiting belongs to LIMD.
- Boundary conditions:
  - A1 = 0: A1T = UGA1.
  - A1 = 16'h8000 and A1 = 16'hFFFF must both follow the negative branch.
  - Wrap-around at 2^16 is silent.
- Scan outputs:
  - RTL drives scan_outN = scan_inN as placeholders.
  - The real chains are stitched by scan insertion.
- Unknown inputs: any X on PK0, PK1, A1 or SIGPK may propagate to A1T. No X may appear on A1T when all inputs are known.

Decomposition:
- Shared ADPCM package holds:
  - coefficient width constant (16);
  - gain constants 16'h00C0 and 16'hFF40;
  - leak bias constant 16'hFF00.
- No sub-module. A single module containing a few continuous assignments is natural.
- An optional local function for the mod-2^16 negate is acceptable.

Test Plan:
- A1=16'h0000, PK0=0, PK1=0, SIGPK=0 -> A1T=16'h00C0.
- A1=16'h0000, PK0=1, PK1=0, SIGPK=0 -> A1T=16'hFF40.
- A1=16'h1000, SIGPK=1, PK0=PK1=1 -> A1T=16'h0FF0 (leak only).
- A1=16'h8000, SIGPK=1 -> A1T=16'h8080 (negative branch, leak toward zero).
- A1=16'hFFFF, PK0=0, PK1=1, SIGPK=0 -> A1T=16'hFF40 (wrap-around discarded).
- Randomised/exhaustive sweep over G.726 normal, overload and homing vector sets for enc/dec, all rates (40/32/24/16) and laws.
  - Apply inputs after the rising edge; compare A1T at the falling edge against the golden vectors.
  - Pulse reset mid-sequence -> A1T unchanged.
